bids_stim_gen: RTL and testbench

Synthesisable, parametrised constrained-random stimulus generator for the BIDS22 bid controller, replacing the fixed-distribution, 3-bidder, simulation-only tester.
- Produces one complete controller transaction per valid/ready handshake: opcode, C_data, C_start, and per-bidder bidAmt/bid/retract.
- Opcode distribution is runtime-programmable, the bidder count is a parameter, and the sequence is seed-reproducible.
- Sits between a BIST/bench sequencer and the BIDS22 driver; also usable on FPGA for soak tests.

---
 rtl/bids_stim_gen_pkg.sv | 56 +++++
 rtl/bids_stim_gen_if.sv | 28 ++
 rtl/bids_stim_gen_lfsr.sv | 33 +++
 rtl/bids_stim_gen.sv | 197 +++++++++++++++++++
 tb/tb_bids_stim_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bids_stim_gen_pkg.sv
// Shared types and constants for the BIDS22 constrained-random stimulus generator:
// controller opcodes, generator states, default opcode weights and the weighted opcode pick.
package bids_stim_gen_pkg;

  localparam int NUM_OPS = 11;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [3:0] {
    OP_NO_OPERATION = 4'd0,
    OP_UNLOCK       = 4'd1,
    OP_LOCK         = 4'd2,
    OP_LOAD_X       = 4'd3,
    OP_LOAD_Y       = 4'd4,
    OP_LOAD_Z       = 4'd5,
    OP_SET_MASK     = 4'd6,
    OP_SET_TIMER    = 4'd7,
    OP_BID_CHARGE   = 4'd8,
    OP_ROUND_ACTIVE = 4'd9,
    OP_ROUND_OVER   = 4'd10
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_OFFER = 2'd2,
    ST_DONE  = 2'd3
  } gen_state_t;

  typedef logic [NUM_OPS-1:0][3:0] weight_tbl_t;

  // Listed from RoundOver (index 10) down to NoOperation (index 0); sums to 16.
  localparam weight_tbl_t DEFAULT_WEIGHTS = {4'd1, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1,
                                             4'd1, 4'd1, 4'd1, 4'd3, 4'd2};

  // Lowest opcode whose running weight sum exceeds the random value scaled into [0, total).
  function automatic operation_t op_select(input logic [7:0] rnd, input weight_tbl_t w);
    logic [7:0]  total;
    logic [7:0]  cum;
    logic [15:0] prod;
    logic        found;
    op_select = OP_NO_OPERATION;
    total = 8'd0;
    for (int i = 0; i < NUM_OPS; i++) total = total + {4'd0, w[i]};
    prod  = {8'd0, rnd} * {8'd0, total};
    cum   = 8'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      cum = cum + {4'd0, w[i]};
      if (!found && (cum > prod[15:8])) begin
        op_select = operation_t'(4'(i));
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/bids_stim_gen_if.sv
// Transaction offer channel between the stimulus generator and the BIDS22 driver.
interface bids_stim_gen_if #(
  parameter int NUM_BIDDERS = 3,
  parameter int AMT_W       = 16,
  parameter int DATA_W      = 32
);
  import bids_stim_gen_pkg::*;

  logic                         stim_valid;
  logic                         stim_ready;
  operation_t                   stim_op;
  logic [DATA_W-1:0]            stim_cdata;
  logic                         stim_cstart;
  logic [NUM_BIDDERS*AMT_W-1:0] stim_bidamt;
  logic [NUM_BIDDERS-1:0]       stim_bid;
  logic [NUM_BIDDERS-1:0]       stim_retract;

  modport master (
    output stim_valid, stim_op, stim_cdata, stim_cstart, stim_bidamt, stim_bid, stim_retract,
    input  stim_ready
  );

  modport slave (
    input  stim_valid, stim_op, stim_cdata, stim_cstart, stim_bidamt, stim_bid, stim_retract,
    output stim_ready
  );

endinterface

// File: rtl/bids_stim_gen_lfsr.sv
// 32-bit right-shifting Galois LFSR with a load port; holds its value unless stepped or loaded.
module bids_lfsr32
  import bids_stim_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2022
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_en,
  input  logic        load_en,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = load_val;
    end else if (step_en) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/bids_stim_gen.sv
// Constrained-random BIDS22 transaction generator: builds one transaction per
// NUM_BIDDERS+2 LFSR steps, then offers it on a valid/ready channel.
module bids_stim_gen
  import bids_stim_gen_pkg::*;
#(
  parameter int          NUM_BIDDERS = 3,
  parameter int          AMT_W       = 16,
  parameter int          DATA_W      = 32,
  parameter int          NUM_TXN     = 1000,
  parameter logic [31:0] SEED        = 32'hACE1_2022
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   seed_load,
  input  logic [31:0]            seed,
  input  logic                   weight_wr,
  input  logic [3:0]             weight_idx,
  input  logic [3:0]             weight_val,
  bids_stim_gen_if.master        stim,
  output logic [31:0]            txn_count,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0]  STEP_LAST = 4'(NUM_BIDDERS + 1);
  localparam logic [31:0] TXN_LIMIT = 32'(NUM_TXN);

  gen_state_t                   state_q, state_d;
  logic [3:0]                   step_q, step_d;
  weight_tbl_t                  weights_q, weights_d;
  operation_t                   op_q, op_d;
  logic [DATA_W-1:0]            cdata_q, cdata_d;
  logic                         cstart_q, cstart_d;
  logic [NUM_BIDDERS*AMT_W-1:0] bidamt_q, bidamt_d;
  logic [NUM_BIDDERS-1:0]       bid_q, bid_d;
  logic [NUM_BIDDERS-1:0]       retract_q, retract_d;
  logic                         valid_q, valid_d;
  logic [31:0]                  txn_count_q, txn_count_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         abort_seen_q, abort_seen_d;

  logic        cfg_ok;
  logic [31:0] lfsr;
  logic [DATA_W-1:0] corner_data;
  logic [AMT_W-1:0]  corner_amt;

  assign cfg_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);

  // A zero seed would lock the LFSR, so it falls back to the reset seed.
  bids_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .step_en  (state_q == ST_GEN),
    .load_en  (cfg_ok && seed_load),
    .load_val ((seed == 32'h0) ? SEED : seed),
    .state    (lfsr)
  );

  // Corner bias: a quarter of values are zero, a quarter all ones, the rest raw LFSR bits.
  always_comb begin
    corner_data = lfsr[DATA_W-1:0];
    corner_amt  = lfsr[AMT_W-1:0];
    if (lfsr[31:30] == 2'b00) begin
      corner_data = '0;
      corner_amt  = '0;
    end else if (lfsr[31:30] == 2'b11) begin
      corner_data = '1;
      corner_amt  = '1;
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    weights_d    = weights_q;
    op_d         = op_q;
    cdata_d      = cdata_q;
    cstart_d     = cstart_q;
    bidamt_d     = bidamt_q;
    bid_d        = bid_q;
    retract_d    = retract_q;
    valid_d      = valid_q;
    txn_count_d  = txn_count_q;
    done_d       = done_q;
    abort_seen_d = abort_seen_q;

    if (cfg_ok && weight_wr && (weight_idx < 4'(NUM_OPS))) begin
      weights_d[weight_idx] = weight_val;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_GEN;
          step_d       = 4'd0;
          txn_count_d  = 32'd0;
          done_d       = 1'b0;
          abort_seen_d = 1'b0;
        end
      end
      ST_GEN: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = 4'd0;
        end else begin
          if (step_q == 4'd0) begin
            op_d = op_select(lfsr[7:0], weights_q);
          end else if (step_q == 4'd1) begin
            cdata_d  = corner_data;
            cstart_d = lfsr[29];
          end
          for (int k = 0; k < NUM_BIDDERS; k++) begin
            if (step_q == 4'(k + 2)) begin
              bidamt_d[k*AMT_W +: AMT_W] = corner_amt;
              bid_d[k]                   = lfsr[29];
              retract_d[k]               = lfsr[28];
            end
          end
          if (step_q == STEP_LAST) begin
            state_d = ST_OFFER;
            step_d  = 4'd0;
            valid_d = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      ST_OFFER: begin
        if (abort) abort_seen_d = 1'b1;
        if (stim.stim_ready) begin
          valid_d     = 1'b0;
          txn_count_d = txn_count_q + 32'd1;
          if ((TXN_LIMIT != 32'd0) && (txn_count_d == TXN_LIMIT)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (abort || abort_seen_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GEN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_GEN) || (state_d == ST_OFFER);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      step_q       <= 4'd0;
      weights_q    <= DEFAULT_WEIGHTS;
      op_q         <= OP_NO_OPERATION;
      cdata_q      <= '0;
      cstart_q     <= 1'b0;
      bidamt_q     <= '0;
      bid_q        <= '0;
      retract_q    <= '0;
      valid_q      <= 1'b0;
      txn_count_q  <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      weights_q    <= weights_d;
      op_q         <= op_d;
      cdata_q      <= cdata_d;
      cstart_q     <= cstart_d;
      bidamt_q     <= bidamt_d;
      bid_q        <= bid_d;
      retract_q    <= retract_d;
      valid_q      <= valid_d;
      txn_count_q  <= txn_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  assign stim.stim_valid   = valid_q;
  assign stim.stim_op      = op_q;
  assign stim.stim_cdata   = cdata_q;
  assign stim.stim_cstart  = cstart_q;
  assign stim.stim_bidamt  = bidamt_q;
  assign stim.stim_bid     = bid_q;
  assign stim.stim_retract = retract_q;
  assign txn_count         = txn_count_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_bids_stim_gen.sv
// Randomized bench for bids_stim_gen, checked against a transaction-level model of the
// LFSR, weighted opcode pick and corner biasing.
module tb_bids_stim_gen;
  import bids_stim_gen_pkg::*;

  localparam int          NB     = 3;
  localparam int          AW     = 16;
  localparam int          DW     = 32;
  localparam int          NT     = 4;
  localparam logic [31:0] SEED_P = 32'hACE1_2022;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, seed_load, weight_wr;
  logic [31:0] seed;
  logic [3:0]  weight_idx, weight_val;
  logic [31:0] txn_count;
  logic        busy, done;

  always #5 clk = ~clk;

  bids_stim_gen_if #(.NUM_BIDDERS(NB), .AMT_W(AW), .DATA_W(DW)) sif ();

  bids_stim_gen #(.NUM_BIDDERS(NB), .AMT_W(AW), .DATA_W(DW), .NUM_TXN(NT), .SEED(SEED_P)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .seed_load  (seed_load),
    .seed       (seed),
    .weight_wr  (weight_wr),
    .weight_idx (weight_idx),
    .weight_val (weight_val),
    .stim       (sif.master),
    .txn_count  (txn_count),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int                op;
    logic [63:0]       cdata;
    logic              cstart;
    logic [63:0]       bidamt;
    logic [NB-1:0]     bid;
    logic [NB-1:0]     retract;
  } txn_t;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] mLfsr;
  int          mW[NUM_OPS];
  int          opSeen[16];
  int          zeroCnt = 0, onesCnt = 0, amtSamples = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse of the control/config inputs.
  task automatic applyStimulus(input logic s_start, input logic s_abort, input logic s_seedLoad,
                               input logic [31:0] s_seed, input logic s_wr,
                               input logic [3:0] s_idx, input logic [3:0] s_val);
    start = s_start; abort = s_abort; seed_load = s_seedLoad; seed = s_seed;
    weight_wr = s_wr; weight_idx = s_idx; weight_val = s_val;
    tick();
    start = 1'b0; abort = 1'b0; seed_load = 1'b0; seed = 32'h0;
    weight_wr = 1'b0; weight_idx = 4'h0; weight_val = 4'h0;
  endtask

  task automatic writeWeight(input int idx, input int val);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'(idx), 4'(val));
    mW[idx] = val;
  endtask

  task automatic setDefaultModel();
    mLfsr = SEED_P;
    mW = '{2, 3, 1, 1, 1, 1, 1, 1, 1, 3, 1};
  endtask

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [63:0] cornerOf(input logic [31:0] l, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (l[31:30] == 2'b00) return 64'd0;
    if (l[31:30] == 2'b11) return mask;
    return {32'h0, l} & mask;
  endfunction

  function automatic int pickOp(input logic [31:0] l);
    int total, scaled, cum;
    total = 0;
    foreach (mW[i]) total += mW[i];
    if (total == 0) return 0;
    scaled = (int'(l[7:0]) * total) / 256;
    cum = 0;
    foreach (mW[i]) begin
      cum += mW[i];
      if (cum > scaled) return i;
    end
    return 0;
  endfunction

  // Consumes NB+2 LFSR values to build the next expected transaction.
  task automatic modelTxn(output txn_t t);
    t.op = 0; t.cdata = 64'd0; t.cstart = 1'b0; t.bidamt = 64'd0; t.bid = '0; t.retract = '0;
    for (int s = 0; s < NB + 2; s++) begin
      if (s == 0) begin
        t.op = pickOp(mLfsr);
      end else if (s == 1) begin
        t.cdata  = cornerOf(mLfsr, DW);
        t.cstart = mLfsr[29];
      end else begin
        t.bidamt     = t.bidamt | (cornerOf(mLfsr, AW) << ((s - 2) * AW));
        t.bid[s-2]     = mLfsr[29];
        t.retract[s-2] = mLfsr[28];
      end
      mLfsr = lfsrNext(mLfsr);
    end
  endtask

  task automatic checkTxn(input txn_t e);
    checkOutput("op",      64'(sif.stim_op),      64'(e.op));
    checkOutput("cdata",   64'(sif.stim_cdata),   e.cdata);
    checkOutput("cstart",  64'(sif.stim_cstart),  64'(e.cstart));
    checkOutput("bidamt",  64'(sif.stim_bidamt),  e.bidamt);
    checkOutput("bid",     64'(sif.stim_bid),     64'(e.bid));
    checkOutput("retract", 64'(sif.stim_retract), 64'(e.retract));
  endtask

  task automatic waitValid();
    int w = 0;
    while (!sif.stim_valid && w < 40) begin
      tick();
      w++;
    end
    checkOutput("offer_valid", 64'(sif.stim_valid), 64'd1);
  endtask

  // Waits for an offer, checks it, optionally stalls, then completes one handshake.
  task automatic takeTxn(input int stall);
    txn_t        e;
    logic [31:0] c0;
    waitValid();
    if (!sif.stim_valid) return;
    modelTxn(e);
    checkTxn(e);
    opSeen[int'(sif.stim_op)]++;
    c0 = txn_count;
    sif.stim_ready = 1'b0;
    repeat (stall) tick();
    if (stall > 0) begin
      checkOutput("stall_valid", 64'(sif.stim_valid), 64'd1);
      checkTxn(e);
    end
    sif.stim_ready = 1'b1;
    tick();
    sif.stim_ready = 1'b0;
    checkOutput("hs_count", 64'(txn_count), 64'(c0 + 32'd1));
    checkOutput("hs_valid_drop", 64'(sif.stim_valid), 64'd0);
  endtask

  task automatic startRun();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    checkOutput("start_done_clr", 64'(done), 64'd0);
    checkOutput("start_count_clr", 64'(txn_count), 64'd0);
    checkOutput("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic checkRunDone();
    checkOutput("run_done", 64'(done), 64'd1);
    checkOutput("run_busy", 64'(busy), 64'd0);
    checkOutput("run_count", 64'(txn_count), 64'(NT));
  endtask

  task automatic runBatch(input int nRuns, input int maxStall);
    for (int r = 0; r < nRuns; r++) begin
      startRun();
      for (int i = 0; i < NT; i++) takeTxn($urandom_range(0, maxStall));
      checkRunDone();
    end
  endtask

  // stim_ready held high: checks every offer plus the handshake-to-handshake spacing.
  task automatic streamRun();
    txn_t e;
    int   cyc = 0;
    int   hs[$];
    sif.stim_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    while (!done && cyc < 200) begin
      if (sif.stim_valid) begin
        modelTxn(e);
        checkTxn(e);
        hs.push_back(cyc);
        for (int k = 0; k < NB; k++) begin
          amtSamples++;
          if (e.bidamt[k*AW +: AW] == 16'h0000) zeroCnt++;
          if (e.bidamt[k*AW +: AW] == 16'hFFFF) onesCnt++;
        end
      end
      tick();
      cyc++;
    end
    sif.stim_ready = 1'b0;
    checkOutput("stream_offers", 64'(hs.size()), 64'(NT));
    for (int i = 1; i < hs.size(); i++) checkOutput("stream_spacing", 64'(hs[i] - hs[i-1]), 64'(NB + 3));
    checkRunDone();
  endtask

  initial begin
    int nonMatch;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0; seed = 32'h0;
    weight_wr = 1'b0; weight_idx = 4'h0; weight_val = 4'h0; sif.stim_ready = 1'b0;
    setDefaultModel();
    foreach (opSeen[i]) opSeen[i] = 0;

    tick(); tick();
    checkOutput("rst_valid",   64'(sif.stim_valid),   64'd0);
    checkOutput("rst_op",      64'(sif.stim_op),      64'd0);
    checkOutput("rst_cdata",   64'(sif.stim_cdata),   64'd0);
    checkOutput("rst_cstart",  64'(sif.stim_cstart),  64'd0);
    checkOutput("rst_bidamt",  64'(sif.stim_bidamt),  64'd0);
    checkOutput("rst_bid",     64'(sif.stim_bid),     64'd0);
    checkOutput("rst_retract", 64'(sif.stim_retract), 64'd0);
    checkOutput("rst_count",   64'(txn_count),        64'd0);
    checkOutput("rst_busy",    64'(busy),             64'd0);
    checkOutput("rst_done",    64'(done),             64'd0);
    reset_n = 1'b1;
    tick();

    $display("[TB] reset-seed sequence, 20 transactions");
    runBatch(5, 2);

    $display("[TB] 10-cycle stall in OFFER");
    startRun();
    takeTxn(10);
    for (int i = 1; i < NT; i++) takeTxn(0);
    checkRunDone();

    $display("[TB] back-to-back throughput");
    streamRun();

    $display("[TB] only LoadX weighted");
    for (int i = 0; i < NUM_OPS; i++) writeWeight(i, (i == 3) ? 5 : 0);
    foreach (opSeen[i]) opSeen[i] = 0;
    runBatch(13, 1);
    nonMatch = 0;
    foreach (opSeen[i]) if (i != 3) nonMatch += opSeen[i];
    checkOutput("only_loadx", 64'(nonMatch), 64'd0);

    $display("[TB] all weights zero");
    writeWeight(3, 0);
    foreach (opSeen[i]) opSeen[i] = 0;
    runBatch(5, 1);
    checkOutput("only_noop", 64'(opSeen[0]), 64'd20);

    $display("[TB] random weights, write while busy ignored");
    for (int i = 0; i < NUM_OPS; i++) writeWeight(i, int'($urandom_range(0, 15)));
    runBatch(5, 2);
    startRun();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 4'd15);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < NT; i++) takeTxn(0);
    checkRunDone();

    $display("[TB] seed_load of zero restores reset seed");
    for (int i = 0; i < NUM_OPS; i++) writeWeight(i, (i == 0) ? 2 : (i == 1 || i == 9) ? 3 : 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 4'h0);
    mLfsr = SEED_P;
    runBatch(2, 1);

    $display("[TB] seed 0x12345678 twice, 100 transactions each");
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 4'h0, 4'h0);
      mLfsr = 32'h1234_5678;
      runBatch(25, 1);
    end

    $display("[TB] abort during OFFER");
    startRun();
    takeTxn(0);
    begin
      txn_t e;
      waitValid();
      modelTxn(e);
      checkTxn(e);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
      checkOutput("abort_offer_hold", 64'(sif.stim_valid), 64'd1);
      sif.stim_ready = 1'b1;
      tick();
      sif.stim_ready = 1'b0;
      checkOutput("abort_offer_busy", 64'(busy), 64'd0);
      checkOutput("abort_offer_done", 64'(done), 64'd0);
      checkOutput("abort_offer_count", 64'(txn_count), 64'd2);
      tick(); tick();
      checkOutput("abort_offer_idle", 64'(busy | sif.stim_valid), 64'd0);
    end

    $display("[TB] abort during GEN");
    startRun();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    mLfsr = lfsrNext(mLfsr);
    checkOutput("abort_gen_busy", 64'(busy), 64'd0);
    checkOutput("abort_gen_valid", 64'(sif.stim_valid), 64'd0);
    tick(); tick();
    checkOutput("abort_gen_idle", 64'(busy | sif.stim_valid), 64'd0);
    runBatch(1, 1);

    $display("[TB] reset mid-run");
    startRun();
    waitValid();
    reset_n = 1'b0;
    tick();
    checkOutput("midrst_valid", 64'(sif.stim_valid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_cdata", 64'(sif.stim_cdata), 64'd0);
    reset_n = 1'b1;
    setDefaultModel();
    tick();
    runBatch(1, 1);

    $display("[TB] corner distribution");
    zeroCnt = 0; onesCnt = 0; amtSamples = 0;
    for (int r = 0; r < 100; r++) streamRun();
    checkOutput("corner_zero_rate",
                64'((zeroCnt * 100 >= amtSamples * 20) && (zeroCnt * 100 <= amtSamples * 30)), 64'd1);
    checkOutput("corner_ones_rate",
                64'((onesCnt * 100 >= amtSamples * 20) && (onesCnt * 100 <= amtSamples * 30)), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
